button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
// PURPOSE
//   Input-side companion of the LED driver: reads the board push-buttons, synchronises and debounces them,
//   and emits clean level and single-cycle event outputs (press, release, long press) plus a running
//   press counter. Sits between the raw button pins and user logic such as the LED pattern controller.
// PARAMETERS
//   NumButtons      4            number of independent button channels (1..8)
//   DebounceCycles  100_0000     consecutive stable Clk cycles required to accept a level change (>=2)
//   LongPressCycles 10000_0000   Clk cycles in debounced-pressed state before LongPress fires (>DebounceCycles)
//   ActiveLow       0            1: raw pin low means pressed (input inverted before synchroniser)
// PORTS
//   Clk         input   1           system clock
//   Reset       input   1           asynchronous, active-high reset
//   Buttons     input   NumButtons  raw asynchronous button pins
//   State       output  NumButtons  debounced pressed level per channel (1 = pressed)
//   Pressed     output  NumButtons  1-cycle pulse when a channel's debounced level goes 0->1
//   Released    output  NumButtons  1-cycle pulse when a channel's debounced level goes 1->0
//   LongPress   output  NumButtons  1-cycle pulse, once per press, after LongPressCycles held
//   PressCount  output  8           total accepted presses across all channels, modulo 256
// BEHAVIOUR
//   - Reset (async, active-high): all outputs 0, all channel FSMs IDLE, all counters 0, both synchroniser
//     stages loaded with the not-pressed level; no events generated on reset release.
//   - Per channel: 2-FF synchroniser after optional inversion; sync output is the only FSM input. All outputs registered.
//   - Per-channel FSM with debounce counter dcnt and long-press counter lcnt (widths via $clog2):
//     IDLE:         sync=1 -> PRESS_WAIT, dcnt=1.
//     PRESS_WAIT:   sync=0 -> IDLE; else if dcnt==DebounceCycles-1 -> HELD, State=1, Pressed pulse, lcnt=0; else dcnt++.
//     HELD:         sync=0 -> RELEASE_WAIT, dcnt=1; else lcnt++ (saturates); Long press fires
//                   exactly once in the cycle lcnt reaches LongPressCycles-1.
//     RELEASE_WAIT: sync=1 -> HELD (no new Pressed, lcnt keeps counting, LongPress still at most once);
//                   else if dcnt==DebounceCycles-1 -> IDLE, State=0, Released pulse; else dcnt++; lcnt keeps counting.
//   - Latency: a level change held stable on Buttons from edge k is reflected on State/Pressed/Released after
//     edge k+DebounceCycles+2 (2 synchroniser edges + DebounceCycles FSM edges), exactly.
//   - Glitch rule: any excursion shorter than DebounceCycles sync cycles produces no State change and no event.
//   - Pulses are exactly one Clk cycle; Pressed and Released never both high on one channel in one cycle.
//   - PressCount += popcount(Pressed) each cycle (simultaneous presses on several channels all counted);
//     wraps 255 -> 0, no saturation, no flag.
//   - Reset mid-press: channel returns to IDLE; a button still held after reset release re-enters
//     PRESS_WAIT and produces a fresh Pressed after the full debounce latency; no Released is emitted.
//   - Channels fully independent; no cross-channel priority or masking.
// TESTING  (DebounceCycles=4, LongPressCycles=16, NumButtons=4, ActiveLow=0)
//   1 Reset asserted, Buttons=4'hF -> all outputs 0; release Reset with Buttons=4'hF -> Pressed=4'hF at edge 6
//     after release, PressCount=4, State=4'hF.
//   2 Buttons[0] 0->1 at edge 0, held -> Pressed[0] high only after edge 6, State[0]=1 from edge 6,
//     LongPress[0] single pulse 15 edges later; holding further -> no repeat.
//   3 Buttons[1] high for 3 cycles then low, repeated 10 times -> State, Pressed, Released, PressCount unchanged.
//   4 Button 2 held, 2-cycle low glitch in HELD -> no Released, no second Pressed; then low for 4+ cycles
//     -> single Released[2] pulse, State[2]=0.
//   5 Channel 3 pressed/released 257 times -> PressCount=1 (wrap); simultaneous press of
//     channels 0 and 1 in same cycle -> PressCount +2.
//   6 ActiveLow=1 build: Buttons idle at 4'hF -> no events; Buttons[0]=0 for 6+ cycles -> Pressed[0] pulse.

Source files
------------

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : button_debouncer
//  Description : Synchronises and debounces NumButtons raw push-button pins.
//                Emits the clean pressed level, single-cycle press / release /
//                long-press pulses and a modulo-256 count of accepted presses.
//  Revision    : 1.0  initial release
// ============================================================================
module button_debouncer #(
    parameter int NumButtons      = 4,
    parameter int DebounceCycles  = 1000000,
    parameter int LongPressCycles = 100000000,
    parameter int ActiveLow       = 0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [NumButtons-1:0] Buttons,
    output logic [NumButtons-1:0] State,
    output logic [NumButtons-1:0] Pressed,
    output logic [NumButtons-1:0] Released,
    output logic [NumButtons-1:0] LongPress,
    output logic [7:0]            PressCount
);

    localparam int c_DCNT_W = $clog2(DebounceCycles);
    localparam int c_LCNT_W = $clog2(LongPressCycles);
    localparam logic [c_DCNT_W-1:0] c_DMAX = c_DCNT_W'(DebounceCycles - 1);
    localparam logic [c_LCNT_W-1:0] c_LMAX = c_LCNT_W'(LongPressCycles - 1);
    localparam logic [c_LCNT_W-1:0] c_LPRE = c_LCNT_W'(LongPressCycles - 2);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_PRESS_WAIT = 2'd1,
        S_HELD       = 2'd2,
        S_REL_WAIT   = 2'd3
    } state_t;

    // Inversion happens before the synchroniser so that the reset value of
    // both stages always means "not pressed".
    logic [NumButtons-1:0] w_pin;
    logic [NumButtons-1:0] r_sync1;
    logic [NumButtons-1:0] r_sync2;

    logic [NumButtons-1:0] w_lvl_nxt;
    logic [NumButtons-1:0] w_press;
    logic [NumButtons-1:0] w_rel;
    logic [NumButtons-1:0] w_long;
    logic [7:0]            w_pop;

    assign w_pin = (ActiveLow != 0) ? ~Buttons : Buttons;

    // Two-flop synchroniser for the raw pins.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_pin;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar gi = 0; gi < NumButtons; gi++) begin : g_ch
        state_t              r_st;
        state_t              w_st_nxt;
        logic [c_DCNT_W-1:0] r_dcnt;
        logic [c_DCNT_W-1:0] w_dcnt_nxt;
        logic [c_LCNT_W-1:0] r_lcnt;
        logic [c_LCNT_W-1:0] w_lcnt_nxt;
        logic [c_LCNT_W-1:0] w_lcnt_step;
        logic                w_sync;
        logic                w_lhit;
        logic                w_press_ch;
        logic                w_rel_ch;
        logic                w_long_ch;

        assign w_sync      = r_sync2[gi];
        // Long-press counter saturates, so the hit value is crossed only once per press.
        assign w_lcnt_step = (r_lcnt == c_LMAX) ? r_lcnt : r_lcnt + 1'b1;
        assign w_lhit      = (r_lcnt == c_LPRE);

        // Channel state and counter registers.
        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                r_st   <= S_IDLE;
                r_dcnt <= '0;
                r_lcnt <= '0;
            end else begin
                r_st   <= w_st_nxt;
                r_dcnt <= w_dcnt_nxt;
                r_lcnt <= w_lcnt_nxt;
            end
        end

        // Debounce FSM: next state, counters and event strobes.
        always_comb begin
            w_st_nxt   = r_st;
            w_dcnt_nxt = r_dcnt;
            w_lcnt_nxt = r_lcnt;
            w_press_ch = 1'b0;
            w_rel_ch   = 1'b0;
            w_long_ch  = 1'b0;
            case (r_st)
                S_IDLE: begin
                    if (w_sync) begin
                        w_st_nxt   = S_PRESS_WAIT;
                        w_dcnt_nxt = c_DCNT_W'(1);
                    end
                end
                S_PRESS_WAIT: begin
                    if (!w_sync) begin
                        w_st_nxt = S_IDLE;
                    end else if (r_dcnt == c_DMAX) begin
                        w_st_nxt   = S_HELD;
                        w_press_ch = 1'b1;
                        w_lcnt_nxt = '0;
                    end else begin
                        w_dcnt_nxt = r_dcnt + 1'b1;
                    end
                end
                S_HELD: begin
                    // Hold time keeps running through a release candidate.
                    w_lcnt_nxt = w_lcnt_step;
                    w_long_ch  = w_lhit;
                    if (!w_sync) begin
                        w_st_nxt   = S_REL_WAIT;
                        w_dcnt_nxt = c_DCNT_W'(1);
                    end
                end
                S_REL_WAIT: begin
                    if (w_sync) begin
                        w_st_nxt   = S_HELD;
                        w_lcnt_nxt = w_lcnt_step;
                        w_long_ch  = w_lhit;
                    end else if (r_dcnt == c_DMAX) begin
                        w_st_nxt = S_IDLE;
                        w_rel_ch = 1'b1;
                    end else begin
                        w_dcnt_nxt = r_dcnt + 1'b1;
                        w_lcnt_nxt = w_lcnt_step;
                        w_long_ch  = w_lhit;
                    end
                end
                default: begin
                    w_st_nxt = S_IDLE;
                end
            endcase
        end

        assign w_press[gi]   = w_press_ch;
        assign w_rel[gi]     = w_rel_ch;
        assign w_long[gi]    = w_long_ch;
        assign w_lvl_nxt[gi] = (w_st_nxt == S_HELD) || (w_st_nxt == S_REL_WAIT);
    end

    // Number of presses accepted on this edge across all channels.
    always_comb begin
        w_pop = '0;
        for (int j = 0; j < NumButtons; j++) begin
            w_pop = w_pop + {7'd0, w_press[j]};
        end
    end

    // Registered outputs; the press counter wraps naturally at 8 bits.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            State      <= '0;
            Pressed    <= '0;
            Released   <= '0;
            LongPress  <= '0;
            PressCount <= '0;
        end else begin
            State      <= w_lvl_nxt;
            Pressed    <= w_press;
            Released   <= w_rel;
            LongPress  <= w_long;
            PressCount <= PressCount + w_pop;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_debouncer
//  Description : Bench for button_debouncer: an active-high and an active-low
//                instance checked every cycle against a run-length model,
//                plus directed checks of the headline scenarios.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_button_debouncer;

    localparam int c_D = 4;
    localparam int c_L = 16;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] btn = 4'hF;
    logic [3:0] btn_l = 4'hF;

    logic [3:0] st [2];
    logic [3:0] pr [2];
    logic [3:0] rl [2];
    logic [3:0] lp [2];
    logic [7:0] pc [2];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: two-sample pin delay, then per channel a count of
    // consecutive samples disagreeing with the accepted level, and the
    // number of samples held since the press was accepted.
    logic [3:0] m_d1 [2];
    logic [3:0] m_d2 [2];
    logic [3:0] m_lvl [2];
    int         m_run [2][4];
    int         m_hold [2][4];
    logic [3:0] e_pr [2];
    logic [3:0] e_rl [2];
    logic [3:0] e_lp [2];
    int         e_cnt [2];

    button_debouncer #(
        .NumButtons(4), .DebounceCycles(c_D), .LongPressCycles(c_L), .ActiveLow(0)
    ) u_dut_hi (
        .Clk(Clk), .Reset(Reset), .Buttons(btn),
        .State(st[0]), .Pressed(pr[0]), .Released(rl[0]),
        .LongPress(lp[0]), .PressCount(pc[0])
    );

    button_debouncer #(
        .NumButtons(4), .DebounceCycles(c_D), .LongPressCycles(c_L), .ActiveLow(1)
    ) u_dut_lo (
        .Clk(Clk), .Reset(Reset), .Buttons(btn_l),
        .State(st[1]), .Pressed(pr[1]), .Released(rl[1]),
        .LongPress(lp[1]), .PressCount(pc[1])
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_d1[k] = '0; m_d2[k] = '0; m_lvl[k] = '0;
            e_pr[k] = '0; e_rl[k] = '0; e_lp[k] = '0; e_cnt[k] = 0;
            for (int c = 0; c < 4; c++) begin
                m_run[k][c] = 0; m_hold[k][c] = 0;
            end
        end
    endtask

    task automatic model_step();
        logic [3:0] in_v;
        logic [3:0] s;
        if (Reset) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            in_v = (k == 0) ? btn : ~btn_l;
            s = m_d2[k];
            m_d2[k] = m_d1[k];
            m_d1[k] = in_v;
            e_pr[k] = '0; e_rl[k] = '0; e_lp[k] = '0;
            for (int c = 0; c < 4; c++) begin
                if (s[c] != m_lvl[k][c]) m_run[k][c]++;
                else m_run[k][c] = 0;
                if (m_run[k][c] == c_D) begin
                    m_run[k][c] = 0;
                    m_lvl[k][c] = s[c];
                    if (s[c]) begin
                        e_pr[k][c] = 1'b1;
                        m_hold[k][c] = 0;
                    end else begin
                        e_rl[k][c] = 1'b1;
                    end
                end else if (m_lvl[k][c] && m_hold[k][c] < c_L - 1) begin
                    m_hold[k][c]++;
                    if (m_hold[k][c] == c_L - 1) e_lp[k][c] = 1'b1;
                end
            end
            e_cnt[k] = (e_cnt[k] + $countones(e_pr[k])) % 256;
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("state%0d", k), 32'(st[k]), 32'(m_lvl[k]));
            chk($sformatf("pressed%0d", k), 32'(pr[k]), 32'(e_pr[k]));
            chk($sformatf("released%0d", k), 32'(rl[k]), 32'(e_rl[k]));
            chk($sformatf("longpress%0d", k), 32'(lp[k]), 32'(e_lp[k]));
            chk($sformatf("presscount%0d", k), 32'(pc[k]), 32'(e_cnt[k]));
        end
    endtask

    // One clock edge: model sees the same pins the DUTs sample, outputs checked 1 time unit later.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            model_step();
            #1;
            compare_all();
        end
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        tick(n);
        Reset = 1'b0;
    endtask

    initial begin
        logic [3:0] acc;
        int         cnt_before;
        int         rel_pulses;
        int         hold_left [8];

        // 1: reset with all buttons pressed, then release reset.
        #1;
        model_reset();
        chk("rst_state", 32'(st[0]), 32'h0);
        chk("rst_count", 32'(pc[0]), 32'h0);
        compare_all();
        tick(3);
        @(posedge Clk); #1;
        model_reset();
        Reset = 1'b0;
        tick(5);
        chk("t1_no_early_press", 32'(pr[0]), 32'h0);
        tick(1);
        chk("t1_pressed", 32'(pr[0]), 32'hF);
        chk("t1_state", 32'(st[0]), 32'hF);
        chk("t1_count", 32'(pc[0]), 32'd4);
        chk("t1_lo_idle", 32'(pr[1] | st[1]), 32'h0);

        // 2: single press latency and one long press.
        btn = 4'h0;
        tick(10);
        btn = 4'h1;
        tick(5);
        chk("t2_before_edge6", 32'(st[0][0]), 32'h0);
        tick(1);
        chk("t2_pressed_edge6", 32'(pr[0]), 32'h1);
        chk("t2_state_edge6", 32'(st[0][0]), 32'h1);
        tick(14);
        chk("t2_no_early_long", 32'(lp[0]), 32'h0);
        tick(1);
        chk("t2_long", 32'(lp[0]), 32'h1);
        acc = '0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            acc |= lp[0];
        end
        chk("t2_no_repeat_long", 32'(acc), 32'h0);
        btn = 4'h0;
        tick(10);

        // 3: short bounces on channel 1 are ignored.
        cnt_before = int'(pc[0]);
        acc = '0;
        for (int r = 0; r < 10; r++) begin
            btn = 4'h2;
            for (int i = 0; i < 3; i++) begin tick(1); acc |= pr[0] | rl[0] | st[0]; end
            btn = 4'h0;
            for (int i = 0; i < 3; i++) begin tick(1); acc |= pr[0] | rl[0] | st[0]; end
        end
        tick(6);
        chk("t3_no_events", 32'(acc), 32'h0);
        chk("t3_count_same", 32'(pc[0]), 32'(cnt_before));

        // 4: glitch while held, then a real release.
        btn = 4'h4;
        tick(8);
        chk("t4_held", 32'(st[0]), 32'h4);
        btn = 4'h0;
        tick(2);
        btn = 4'h4;
        acc = '0;
        for (int i = 0; i < 12; i++) begin tick(1); acc |= pr[0] | rl[0]; end
        chk("t4_glitch_no_event", 32'(acc), 32'h0);
        chk("t4_still_held", 32'(st[0]), 32'h4);
        btn = 4'h0;
        rel_pulses = 0;
        for (int i = 0; i < 10; i++) begin tick(1); rel_pulses += int'(rl[0][2]); end
        chk("t4_one_release", 32'(rel_pulses), 32'd1);
        chk("t4_state_low", 32'(st[0]), 32'h0);

        // 5: counter wrap after 257 presses, then a simultaneous double press.
        do_reset(2);
        for (int r = 0; r < 257; r++) begin
            btn = 4'h8;
            tick(6);
            btn = 4'h0;
            tick(6);
        end
        tick(2);
        chk("t5_wrap", 32'(pc[0]), 32'd1);
        btn = 4'h3;
        tick(6);
        chk("t5_dual_pressed", 32'(pr[0]), 32'h3);
        chk("t5_dual_count", 32'(pc[0]), 32'd3);
        btn = 4'h0;
        tick(8);

        // Reset while held: fresh press after full latency, no release.
        btn = 4'h1;
        tick(10);
        do_reset(1);
        chk("rst_mid_state", 32'(st[0]), 32'h0);
        acc = '0;
        for (int i = 0; i < 5; i++) begin tick(1); acc |= pr[0] | rl[0]; end
        chk("rst_mid_quiet", 32'(acc), 32'h0);
        tick(1);
        chk("rst_mid_repress", 32'(pr[0]), 32'h1);
        btn = 4'h0;
        tick(8);

        // 6: active-low instance.
        btn_l = 4'hE;
        tick(5);
        chk("t6_no_early", 32'(pr[1]), 32'h0);
        tick(1);
        chk("t6_pressed", 32'(pr[1]), 32'h1);
        chk("t6_state", 32'(st[1]), 32'h1);
        btn_l = 4'hF;
        tick(8);

        // Random hold lengths per pin, occasional resets; model checks every edge.
        for (int c = 0; c < 8; c++) hold_left[c] = int'($urandom_range(1, 24));
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < 8; c++) begin
                hold_left[c]--;
                if (hold_left[c] <= 0) begin
                    if (c < 4) btn[c] = ~btn[c];
                    else btn_l[c-4] = ~btn_l[c-4];
                    hold_left[c] = int'($urandom_range(1, 24));
                end
            end
            if ($urandom_range(0, 599) == 0) do_reset(int'($urandom_range(1, 2)));
            else tick(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
